// File: rtl/smol_rf_wb_arbiter.sv
// smol_rf_wb_arbiter: writeback arbiter for the SmolCore 32x32 register file.
// NUM_REQ writeback sources compete for the single RF write port. The arbiter grants
// round-robin with a combinational ready, and it registers one write per cycle toward the RF.
// Writes to x0 are accepted but never assert rf_wEnable.
// Optional feature: define SMOL_RF_WB_BYPASS_EN to add the read-bypass ports. These cover
// the write that is staged on the RF port and that the RF only commits at the next edge.
module smol_rf_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_stall,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic                  rf_wEnable,
    output logic [AW-1:0]         rf_wAddr,
    output logic [DW-1:0]         rf_wData,
`ifdef SMOL_RF_WB_BYPASS_EN
    input  logic [AW-1:0]         byp_rAddr1,
    input  logic [AW-1:0]         byp_rAddr2,
    input  logic [DW-1:0]         rf_rData1,
    input  logic [DW-1:0]         rf_rData2,
    output logic [DW-1:0]         byp_rData1,
    output logic [DW-1:0]         byp_rData2,
`endif
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_data;
    logic          xfer;
    logic          multi_valid;

    // Round-robin search from rr_ptr_q. The loop runs from the farthest offset down, so the
    // nearest valid requester is written last and wins.
    always_comb begin
        int idx;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_addr = '0;
        gnt_data = '0;
        idx      = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (req_valid[idx]) begin
                gnt_any  = 1'b1;
                gnt_idx  = PW'(idx);
                gnt_addr = req_addr[idx*AW +: AW];
                gnt_data = req_data[idx*DW +: DW];
            end
        end
    end

    // Ready is a pure grant decode. Stall and reset both suppress it.
    always_comb begin
        xfer      = gnt_any && !wb_stall && !rst;
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
        if (gnt_idx == PW'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = gnt_idx + PW'(1);
        end
        // At least two bits are set exactly when clearing the lowest set bit leaves something.
        multi_valid = |(req_valid & (req_valid - NUM_REQ'(1)));
    end

    // Output stage, rotation pointer and saturating conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wEnable   <= 1'b0;
            rf_wAddr     <= '0;
            rf_wData     <= '0;
            rr_ptr_q     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (xfer) begin
                rf_wEnable <= (gnt_addr != '0);
                rf_wAddr   <= gnt_addr;
                rf_wData   <= gnt_data;
                rr_ptr_q   <= rr_ptr_d;
            end else begin
                rf_wEnable <= 1'b0;
            end
            if (!wb_stall && multi_valid && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SMOL_RF_WB_BYPASS_EN
    // Forward the staged write to readers of the same register. x0 is never forwarded.
    always_comb begin
        byp_rData1 = rf_rData1;
        byp_rData2 = rf_rData2;
        if (rf_wEnable && (rf_wAddr == byp_rAddr1) && (byp_rAddr1 != '0)) begin
            byp_rData1 = rf_wData;
        end
        if (rf_wEnable && (rf_wAddr == byp_rAddr2) && (byp_rAddr2 != '0)) begin
            byp_rData2 = rf_wData;
        end
    end
`endif

endmodule

// File: tb/tb_smol_rf_wb_arbiter.sv
// Testbench for smol_rf_wb_arbiter (NUM_REQ=3, AW=5, DW=32, CNT_W=16).
// Directed scenarios come first, then randomized traffic checked against a reference model.
// Define SMOL_RF_WB_BYPASS_EN to also exercise the read-bypass ports.
module tb_smol_rf_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_stall;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            rf_wEnable;
    logic [AW-1:0]   rf_wAddr;
    logic [DW-1:0]   rf_wData;
    logic [15:0]     conflict_cnt;
`ifdef SMOL_RF_WB_BYPASS_EN
    logic [AW-1:0]   byp_rAddr1, byp_rAddr2;
    logic [DW-1:0]   rf_rData1, rf_rData2, byp_rData1, byp_rData2;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_rr;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_cnt;
    logic        v[N];
    logic [4:0]  a[N];
    logic [31:0] d[N];
    int          g;
    logic [N-1:0] exp_ready;

    smol_rf_wb_arbiter #(
        .NUM_REQ(N), .AW(AW), .DW(DW), .CNT_W(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_stall    (wb_stall),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_wEnable  (rf_wEnable),
        .rf_wAddr    (rf_wAddr),
        .rf_wData    (rf_wData),
`ifdef SMOL_RF_WB_BYPASS_EN
        .byp_rAddr1  (byp_rAddr1),
        .byp_rAddr2  (byp_rAddr2),
        .rf_rData1   (rf_rData1),
        .rf_rData2   (rf_rData2),
        .byp_rData1  (byp_rData1),
        .byp_rData2  (byp_rData2),
`endif
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        wb_stall  = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [4:0] ad, input logic [31:0] dt);
        req_addr[i*AW +: AW] = ad;
        req_data[i*DW +: DW] = dt;
    endtask

    initial begin
        rst       = 1'b1;
        wb_stall  = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
`ifdef SMOL_RF_WB_BYPASS_EN
        byp_rAddr1 = '0;
        byp_rAddr2 = '0;
        rf_rData1  = '0;
        rf_rData2  = '0;
`endif
        #1;

        // 1: reset with every requester valid
        set_req(0, 5'd1, 32'h11);
        set_req(1, 5'd2, 32'h22);
        set_req(2, 5'd3, 32'h33);
        req_valid = 3'b111;
        tick();
        check_eq("rst_ready_a", req_ready, 3'b000);
        tick();
        check_eq("rst_ready_b", req_ready, 3'b000);
        check_eq("rst_wen", rf_wEnable, 1'b0);
        check_eq("rst_cnt", conflict_cnt, 16'd0);
        check_eq("rst_waddr", rf_wAddr, 5'd0);
        req_valid = '0;
        rst = 1'b0;

        // 2: single requester
        req_valid = 3'b010;
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        #1 check_eq("single_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        #1;
        check_eq("single_wen", rf_wEnable, 1'b1);
        check_eq("single_waddr", rf_wAddr, 5'd5);
        check_eq("single_wdata", rf_wData, 32'hDEAD_BEEF);
        req_valid = 3'b111;
        #1 check_eq("single_rr2", req_ready, 3'b100);
        req_valid = '0;
        tick();

        // 3: round-robin over six cycles
        do_reset();
        set_req(0, 5'd1, 32'h100);
        set_req(1, 5'd2, 32'h200);
        set_req(2, 5'd3, 32'h300);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            exp_ready = '0;
            exp_ready[c % 3] = 1'b1;
            #1 check_eq("rr_grant", req_ready, exp_ready);
            if (c > 0) check_eq("rr_prev_addr", rf_wAddr, 5'((c - 1) % 3 + 1));
            tick();
        end
        req_valid = '0;
        #1;
        check_eq("rr_cnt", conflict_cnt, 16'd6);
        check_eq("rr_last_data", rf_wData, 32'h300);

        // 4: write to x0
        do_reset();
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        req_valid = 3'b001;
        #1 check_eq("x0_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1 check_eq("x0_wen", rf_wEnable, 1'b0);
        set_req(0, 5'd4, 32'h4);
        req_valid = 3'b111;
        #1 check_eq("x0_rr1", req_ready, 3'b010);
        req_valid = '0;
        tick();

        // 5: stall behind a staged write
        do_reset();
        set_req(0, 5'd9, 32'h55);
        set_req(1, 5'd10, 32'h66);
        req_valid = 3'b001;
        tick();
        wb_stall  = 1'b1;
        req_valid = 3'b011;
        #1;
        check_eq("stall_ready", req_ready, 3'b000);
        check_eq("stall_wen", rf_wEnable, 1'b1);
        check_eq("stall_waddr", rf_wAddr, 5'd9);
        tick();
        #1;
        check_eq("stall_wen2", rf_wEnable, 1'b0);
        check_eq("stall_cnt", conflict_cnt, 16'd0);
        wb_stall = 1'b0;
        #1 check_eq("stall_rr_kept", req_ready, 3'b010);
        tick();
        req_valid = '0;
        #1 check_eq("stall_cnt_after", conflict_cnt, 16'd1);

`ifdef SMOL_RF_WB_BYPASS_EN
        // 6: bypass of the staged write
        do_reset();
        set_req(2, 5'd7, 32'h1234);
        req_valid = 3'b100;
        tick();
        req_valid  = '0;
        byp_rAddr1 = 5'd7;
        rf_rData1  = 32'h0;
        byp_rAddr2 = 5'd0;
        rf_rData2  = 32'hABCD;
        #1;
        check_eq("byp1_hit", byp_rData1, 32'h1234);
        check_eq("byp2_x0", byp_rData2, 32'hABCD);
        byp_rAddr1 = 5'd8;
        rf_rData1  = 32'h77;
        #1 check_eq("byp1_miss", byp_rData1, 32'h77);
        tick();
`endif

        // Randomized traffic against the reference model
        do_reset();
        m_rr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            // Fresh requests only for idle requesters; pending ones hold addr/data
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom_range(1, 0) == 1)) begin
                    v[i] = 1'b1;
                    a[i] = 5'($urandom_range(31, 0));
                    d[i] = $urandom;
                end
                req_valid[i] = v[i];
                set_req(i, a[i], d[i]);
            end
            wb_stall = ($urandom_range(4, 0) == 0);
            #1;
            g = -1;
            if (!wb_stall) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check_eq("rand_ready", req_ready, exp_ready);
            check_eq("rand_wen", rf_wEnable, m_wen);
            check_eq("rand_waddr", rf_wAddr, m_waddr);
            check_eq("rand_wdata", rf_wData, m_wdata);
            check_eq("rand_cnt", conflict_cnt, 16'(m_cnt));
            // Model effect of the coming edge
            if (!wb_stall && $countones(req_valid) >= 2 && m_cnt < 65535) m_cnt++;
            if (g >= 0) begin
                m_wen   = (a[g] != 5'd0);
                m_waddr = a[g];
                m_wdata = d[g];
                m_rr    = (g + 1) % N;
                v[g]    = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
